// File: rtl/writeback_stage_pipe_if.sv
// MEM/WB boundary bundle: MEM-side instruction/data inputs, stall/flush controls and register-file write outputs.
// master = upstream pipeline driver, slave = writeback stage; WB_HISTORY_EN adds the previous-write bypass outputs.
interface writeback_stage_pipe_if #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
);
  logic              StallW;
  logic              FlushW;
  logic              ValidM;
  logic              RegWriteM;
  logic [REG_AW-1:0] RdM;
  logic [1:0]        ResultSrcM;
  logic              LoadM;
  logic [2:0]        Funct3M;
  logic [XLEN-1:0]   ALU_ResultM;
  logic [XLEN-1:0]   PCPlus4M;
  logic [XLEN-1:0]   ImmExtM;
  logic [XLEN-1:0]   ReadDataM;
  logic              ReadValidM;

  logic              ValidW;
  logic              RegWriteW;
  logic [REG_AW-1:0] RdW;
  logic [XLEN-1:0]   ResultW;
  logic              LoadStallW;
`ifdef WB_HISTORY_EN
  logic              PrevWrW;
  logic [REG_AW-1:0] PrevRdW;
  logic [XLEN-1:0]   PrevResultW;
`endif

  modport master (
    output StallW, FlushW, ValidM, RegWriteM, RdM, ResultSrcM, LoadM, Funct3M,
           ALU_ResultM, PCPlus4M, ImmExtM, ReadDataM, ReadValidM,
`ifdef WB_HISTORY_EN
    input  PrevWrW, PrevRdW, PrevResultW,
`endif
    input  ValidW, RegWriteW, RdW, ResultW, LoadStallW
  );

  modport slave (
    input  StallW, FlushW, ValidM, RegWriteM, RdM, ResultSrcM, LoadM, Funct3M,
           ALU_ResultM, PCPlus4M, ImmExtM, ReadDataM, ReadValidM,
`ifdef WB_HISTORY_EN
    output PrevWrW, PrevRdW, PrevResultW,
`endif
    output ValidW, RegWriteW, RdW, ResultW, LoadStallW
  );
endinterface

// File: rtl/writeback_stage_pipe.sv
// RISC-V writeback stage: MEM/WB register, 4-way result select, load align/extend; optional WB_HISTORY_EN bypass copy.
// Latency 1 cycle; a load captured without data parks in WAIT_LD and raises LoadStallW until ReadValidM.
module writeback_stage_pipe #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  writeback_stage_pipe_if.slave wb
);

  localparam int OFFW = (XLEN == 64) ? 3 : 2;

  typedef enum logic {RUN, WAIT_LD} state_e;

  state_e            state_q, state_d;
  logic              valid_q, valid_d;
  logic              regwr_q, regwr_d;
  logic [REG_AW-1:0] rd_q, rd_d;
  logic [1:0]        src_q, src_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [OFFW-1:0]   off_q, off_d;
  logic [XLEN-1:0]   result_q, result_d;

  function automatic logic [XLEN-1:0] load_extract(
    input logic [XLEN-1:0] data,
    input logic [2:0]      f3,
    input logic [OFFW-1:0] off
  );
    logic [7:0]      b;
    logic [15:0]     h;
    logic [31:0]     w;
    logic [XLEN-1:0] r;
    b = 8'(data >> {off, 3'b000});
    h = 16'(data >> {off[OFFW-1:1], 4'b0000});
    // The word lane only moves on RV64; on RV32 the word is the whole bus.
    w = (XLEN == 64) ? 32'(data >> {off[OFFW-1], 5'b00000}) : 32'(data);
    case (f3)
      3'b000:  r = XLEN'($signed(b));
      3'b100:  r = XLEN'(b);
      3'b001:  r = XLEN'($signed(h));
      3'b101:  r = XLEN'(h);
      3'b010:  r = XLEN'($signed(w));
      3'b110:  r = (XLEN == 64) ? XLEN'(w) : data;
      default: r = data;
    endcase
    return r;
  endfunction

  always_comb begin
    state_d  = state_q;
    valid_d  = valid_q;
    regwr_d  = regwr_q;
    rd_d     = rd_q;
    src_d    = src_q;
    funct3_d = funct3_q;
    off_d    = off_q;
    result_d = result_q;

    if (wb.FlushW) begin
      state_d = RUN;
      valid_d = 1'b0;
    end else if (state_q == WAIT_LD) begin
      if (wb.ReadValidM && src_q == 2'b01) begin
        result_d = load_extract(wb.ReadDataM, funct3_q, off_q);
        valid_d  = 1'b1;
        state_d  = RUN;
      end
    end else if (!wb.StallW) begin
      if (wb.ValidM) begin
        regwr_d  = wb.RegWriteM;
        rd_d     = wb.RdM;
        src_d    = wb.ResultSrcM;
        funct3_d = wb.Funct3M;
        off_d    = wb.ALU_ResultM[OFFW-1:0];
        if (wb.ResultSrcM == 2'b01 && wb.LoadM && !wb.ReadValidM) begin
          valid_d = 1'b0;
          state_d = WAIT_LD;
        end else begin
          valid_d = 1'b1;
          case (wb.ResultSrcM)
            2'b00:   result_d = wb.ALU_ResultM;
            2'b01:   result_d = load_extract(wb.ReadDataM, wb.Funct3M, wb.ALU_ResultM[OFFW-1:0]);
            2'b10:   result_d = wb.PCPlus4M;
            default: result_d = wb.ImmExtM;
          endcase
        end
      end else begin
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= RUN;
      valid_q  <= 1'b0;
      regwr_q  <= 1'b0;
      rd_q     <= '0;
      src_q    <= '0;
      funct3_q <= '0;
      off_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      valid_q  <= valid_d;
      regwr_q  <= regwr_d;
      rd_q     <= rd_d;
      src_q    <= src_d;
      funct3_q <= funct3_d;
      off_q    <= off_d;
      result_q <= result_d;
    end
  end

  assign wb.ValidW     = valid_q;
  assign wb.RegWriteW  = valid_q & regwr_q & (rd_q != '0);
  assign wb.RdW        = rd_q;
  assign wb.ResultW    = result_q;
  assign wb.LoadStallW = (state_q == WAIT_LD);

`ifdef WB_HISTORY_EN
  logic              prev_wr_q, prev_wr_d;
  logic [REG_AW-1:0] prev_rd_q, prev_rd_d;
  logic [XLEN-1:0]   prev_result_q, prev_result_d;

  always_comb begin
    prev_wr_d     = wb.RegWriteW;
    prev_rd_d     = rd_q;
    prev_result_d = result_q;
    if (wb.FlushW) begin
      prev_wr_d     = 1'b0;
      prev_rd_d     = '0;
      prev_result_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_wr_q     <= 1'b0;
      prev_rd_q     <= '0;
      prev_result_q <= '0;
    end else begin
      prev_wr_q     <= prev_wr_d;
      prev_rd_q     <= prev_rd_d;
      prev_result_q <= prev_result_d;
    end
  end

  assign wb.PrevWrW     = prev_wr_q;
  assign wb.PrevRdW     = prev_rd_q;
  assign wb.PrevResultW = prev_result_q;
`endif

endmodule

// File: tb/tb_writeback_stage_pipe.sv
// Drives an RV32 and an RV64 writeback stage with identical stimulus and checks both against one reference model.
module tb_writeback_stage_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0, flush = 1'b0, vm = 1'b0, rw = 1'b0, rv = 1'b0;
  logic [4:0]  rd = '0;
  logic [1:0]  src = '0;
  logic [2:0]  f3 = '0;
  logic [63:0] alu = '0, pc4 = '0, imm = '0, rdata = '0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  writeback_stage_pipe_if #(.XLEN(32), .REG_AW(5)) if32 ();
  writeback_stage_pipe_if #(.XLEN(64), .REG_AW(5)) if64 ();

  assign if32.StallW = stall;       assign if64.StallW = stall;
  assign if32.FlushW = flush;       assign if64.FlushW = flush;
  assign if32.ValidM = vm;          assign if64.ValidM = vm;
  assign if32.RegWriteM = rw;       assign if64.RegWriteM = rw;
  assign if32.RdM = rd;             assign if64.RdM = rd;
  assign if32.ResultSrcM = src;     assign if64.ResultSrcM = src;
  assign if32.LoadM = (src == 2'b01); assign if64.LoadM = (src == 2'b01);
  assign if32.Funct3M = f3;         assign if64.Funct3M = f3;
  assign if32.ALU_ResultM = alu[31:0];   assign if64.ALU_ResultM = alu;
  assign if32.PCPlus4M = pc4[31:0];      assign if64.PCPlus4M = pc4;
  assign if32.ImmExtM = imm[31:0];       assign if64.ImmExtM = imm;
  assign if32.ReadDataM = rdata[31:0];   assign if64.ReadDataM = rdata;
  assign if32.ReadValidM = rv;      assign if64.ReadValidM = rv;

  writeback_stage_pipe #(.XLEN(32), .REG_AW(5)) dut32 (.clk(clk), .rst(rst), .wb(if32));
  writeback_stage_pipe #(.XLEN(64), .REG_AW(5)) dut64 (.clk(clk), .rst(rst), .wb(if64));

  // Reference model state
  bit          m_pend, m_valid, m_rw;
  logic [4:0]  m_rd;
  logic [2:0]  m_f3;
  logic [63:0] m_addr, m_res32, m_res64;
`ifdef WB_HISTORY_EN
  bit          m_pwr;
  logic [4:0]  m_prd;
  logic [63:0] m_pres32, m_pres64;
`endif

  function automatic logic [63:0] ext(input int xlen, input logic [2:0] fn,
                                      input logic [63:0] addr, input logic [63:0] data);
    longint unsigned d, v;
    int off, w;
    bit sgn;
    d   = (xlen == 32) ? (data & 64'hFFFF_FFFF) : data;
    off = (xlen == 64) ? int'(addr & 64'd7) : int'(addr & 64'd3);
    w = xlen; sgn = 1'b0; v = d;
    case (fn)
      3'd0, 3'd4: begin w = 8;  v = (d >> (8 * off)) & 64'hFF;            sgn = (fn == 3'd0); end
      3'd1, 3'd5: begin w = 16; v = (d >> (16 * (off / 2))) & 64'hFFFF;   sgn = (fn == 3'd1); end
      3'd2: if (xlen == 64) begin w = 32; v = (d >> (32 * (off / 4))) & 64'hFFFF_FFFF; sgn = 1'b1; end
      3'd6: if (xlen == 64) begin w = 32; v = (d >> (32 * (off / 4))) & 64'hFFFF_FFFF; end
      default: ;
    endcase
    if (sgn && (((v >> (w - 1)) & 64'd1) != 0)) v = v | ~((64'd1 << w) - 64'd1);
    if (xlen == 32) v = v & 64'hFFFF_FFFF;
    return v;
  endfunction

  function automatic logic [63:0] pick(input int xlen);
    logic [63:0] r;
    case (src)
      2'd0:    r = alu;
      2'd1:    r = ext(xlen, f3, alu, rdata);
      2'd2:    r = pc4;
      default: r = imm;
    endcase
    return (xlen == 32) ? (r & 64'hFFFF_FFFF) : r;
  endfunction

  function automatic bit m_wr();
    return m_valid && m_rw && (m_rd != 5'd0);
  endfunction

  task automatic model_reset();
    m_pend = 0; m_valid = 0; m_rw = 0; m_rd = '0; m_f3 = '0;
    m_addr = '0; m_res32 = '0; m_res64 = '0;
`ifdef WB_HISTORY_EN
    m_pwr = 0; m_prd = '0; m_pres32 = '0; m_pres64 = '0;
`endif
  endtask

  task automatic model_edge();
`ifdef WB_HISTORY_EN
    m_pwr    = flush ? 1'b0 : m_wr();
    m_prd    = flush ? 5'd0 : m_rd;
    m_pres32 = flush ? 64'd0 : m_res32;
    m_pres64 = flush ? 64'd0 : m_res64;
`endif
    if (flush) begin
      m_pend = 0; m_valid = 0;
    end else if (m_pend) begin
      if (rv) begin
        m_res32 = ext(32, m_f3, m_addr, rdata);
        m_res64 = ext(64, m_f3, m_addr, rdata);
        m_valid = 1; m_pend = 0;
      end
    end else if (!stall) begin
      if (vm) begin
        m_rw = rw; m_rd = rd; m_f3 = f3; m_addr = alu;
        if (src == 2'b01 && !rv) begin
          m_pend = 1; m_valid = 0;
        end else begin
          m_valid = 1; m_res32 = pick(32); m_res64 = pick(64);
        end
      end else begin
        m_valid = 0;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("valid32", if32.ValidW, m_valid);
    chk("valid64", if64.ValidW, m_valid);
    chk("regwr32", if32.RegWriteW, m_wr());
    chk("regwr64", if64.RegWriteW, m_wr());
    chk("rd32", if32.RdW, m_rd);
    chk("rd64", if64.RdW, m_rd);
    chk("ldstall32", if32.LoadStallW, m_pend);
    chk("ldstall64", if64.LoadStallW, m_pend);
    if (m_valid) begin
      chk("result32", if32.ResultW, m_res32);
      chk("result64", if64.ResultW, m_res64);
    end
`ifdef WB_HISTORY_EN
    chk("prevwr32", if32.PrevWrW, m_pwr);
    chk("prevrd64", if64.PrevRdW, m_prd);
    chk("prevres32", if32.PrevResultW, m_pres32);
    chk("prevres64", if64.PrevResultW, m_pres64);
`endif
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic drive(input logic v, input logic w, input logic [4:0] r, input logic [1:0] s,
                       input logic [2:0] fn, input logic [63:0] a, input logic [63:0] d, input logic dv);
    vm = v; rw = w; rd = r; src = s; f3 = fn; alu = a; rdata = d; rv = dv;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_valid"}, {if32.ValidW, if64.ValidW}, 64'd0);
    chk({tag, "_regwr"}, {if32.RegWriteW, if64.RegWriteW}, 64'd0);
    chk({tag, "_rd"}, {if32.RdW, if64.RdW}, 64'd0);
    chk({tag, "_res32"}, if32.ResultW, 64'd0);
    chk({tag, "_res64"}, if64.ResultW, 64'd0);
    chk({tag, "_ldstall"}, {if32.LoadStallW, if64.LoadStallW}, 64'd0);
  endtask

  initial begin
    model_reset();
    pc4 = 64'h0000_0001_0000_0104;
    imm = 64'hFFFF_FFFF_ABCD_E000;
    #2;
    check_reset_outputs("reset");
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // ALU op to rd 5
    drive(1, 1, 5'd5, 2'b00, 3'b000, 64'h1234, 64'h0, 0);
    step();
    chk("alu_result_lit", if32.ResultW, 64'h1234);
    chk("alu_regwr_lit", if32.RegWriteW, 64'd1);

    // On-time loads: LB, LBU, LHU
    drive(1, 1, 5'd6, 2'b01, 3'b000, 64'h2, 64'h0080_0000, 1);
    step();
    chk("lb_lit", if32.ResultW, 64'hFFFF_FF80);
    drive(1, 1, 5'd6, 2'b01, 3'b100, 64'h2, 64'h0080_0000, 1);
    step();
    chk("lbu_lit", if32.ResultW, 64'h0000_0080);
    drive(1, 1, 5'd6, 2'b01, 3'b101, 64'h2, 64'hBEEF_0000, 1);
    step();
    chk("lhu_lit", if32.ResultW, 64'h0000_BEEF);

    // PC+4 and immediate sources
    drive(1, 1, 5'd1, 2'b10, 3'b000, 64'h0, 64'h0, 0);
    step();
    drive(1, 1, 5'd2, 2'b11, 3'b000, 64'h0, 64'h0, 0);
    step();

    // Late LW: data arrives three cycles after capture
    drive(1, 1, 5'd9, 2'b01, 3'b010, 64'h0, 64'h0, 0);
    step();
    drive(0, 0, 5'd0, 2'b00, 3'b000, 64'h0, 64'h0, 0);
    step();
    step();
    chk("late_stall_lit", if32.LoadStallW, 64'd1);
    rdata = 64'h0000_0000_CAFE_F00D; rv = 1;
    step();
    chk("late_result_lit", if32.ResultW, 64'hCAFE_F00D);
    chk("late_stall_clear_lit", if32.LoadStallW, 64'd0);

    // Flush abandons a pending load
    drive(1, 1, 5'd10, 2'b01, 3'b010, 64'h0, 64'h0, 0);
    step();
    drive(0, 0, 5'd0, 2'b00, 3'b000, 64'h0, 64'h0, 0);
    flush = 1;
    step();
    flush = 0; rv = 1; rdata = 64'h1111_2222_3333_4444;
    step();
    step();
    chk("flush_noregwr_lit", if32.RegWriteW, 64'd0);

    // Write to x0 never asserts RegWriteW
    drive(1, 1, 5'd0, 2'b00, 3'b000, 64'h55, 64'h0, 0);
    step();
    chk("x0_lit", if32.RegWriteW, 64'd0);

    // Valid write to rd 7 then two stall cycles with a different instruction offered
    drive(1, 1, 5'd7, 2'b00, 3'b000, 64'h77, 64'h0, 0);
    step();
    drive(1, 1, 5'd8, 2'b00, 3'b000, 64'h88, 64'h0, 0);
    stall = 1;
    step();
    step();
    chk("stall_rd_lit", if32.RdW, 64'd7);
    chk("stall_res_lit", if32.ResultW, 64'h77);
    stall = 0;

    // RV64 LWU at offset 4
    drive(1, 1, 5'd12, 2'b01, 3'b110, 64'h4, 64'h8000_0001_1234_5678, 1);
    step();
    chk("lwu64_lit", if64.ResultW, 64'h0000_0000_8000_0001);

    // Asynchronous reset while waiting on a load
    drive(1, 1, 5'd13, 2'b01, 3'b000, 64'h1, 64'h0, 0);
    step();
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    check_reset_outputs("midreset");
    @(negedge clk);
    rst = 1'b1;

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      flush = ($urandom_range(0, 15) == 0);
      stall = ($urandom_range(0, 5) == 0);
      vm    = ($urandom_range(0, 3) != 0);
      rw    = $urandom_range(0, 1);
      rd    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      src   = 2'($urandom);
      f3    = 3'($urandom);
      alu   = {$urandom, $urandom};
      rdata = {$urandom, $urandom};
      rv    = ($urandom_range(0, 2) != 0);
      pc4   = {$urandom, $urandom};
      imm   = {$urandom, $urandom};
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
